// File: rtl/anti_theft_pkg.sv
// Shared constants and state encoding for the vehicle anti-theft controller.
package anti_theft_pkg;

  localparam int unsigned DEF_TW          = 4;
  localparam int unsigned DEF_T_ARM_DELAY = 6;
  localparam int unsigned DEF_T_DRIVER    = 8;
  localparam int unsigned DEF_T_PASSENGER = 15;
  localparam int unsigned DEF_T_ALARM_ON  = 10;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    DISARMED  = 3'd0,
    ARMING    = 3'd1,
    ARMED     = 3'd2,
    TRIGGERED = 3'd3,
    ALARM     = 3'd4
  } state_t;

endpackage

// File: rtl/anti_theft_alarm_timer.sv
// Loadable down-counter advanced by the 1 Hz enable; expired while the count sits at zero.
module alarm_timer
  import anti_theft_pkg::*;
#(
  parameter int unsigned W = DEF_TW
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  // A load in the same cycle as a tick keeps the freshly loaded value intact.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/anti_theft_alarm.sv
// Anti-theft controller: arm after driver exit, entry grace on door open, timed siren.
module anti_theft_alarm
  import anti_theft_pkg::*;
#(
  parameter int unsigned TW          = DEF_TW,
  parameter int unsigned T_ARM_DELAY = DEF_T_ARM_DELAY,
  parameter int unsigned T_DRIVER    = DEF_T_DRIVER,
  parameter int unsigned T_PASSENGER = DEF_T_PASSENGER,
  parameter int unsigned T_ALARM_ON  = DEF_T_ALARM_ON
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               one_hz_en,
  input  logic               ignition,
  input  logic               door_driver,
  input  logic               door_pass,
  output logic               siren,
  output logic               status_led,
  output logic               fuel_inhibit,
  output logic [STATE_W-1:0] state_dbg
);

  state_t        state;
  state_t        next_state;
  logic          door_q;
  logic          close_edge;
  logic          prev_armed;
  logic          load;
  logic [TW-1:0] load_value;
  logic          expired;
  logic          siren_c;
  logic          led_c;
  logic          fuel_c;

  alarm_timer #(.W(TW)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .tick    (one_hz_en),
    .load    (load),
    .value   (load_value),
    .expired (expired)
  );

  assign close_edge = door_q & ~door_driver;
  assign state_dbg  = state;

  // State, door history and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= DISARMED;
      door_q       <= 1'b0;
      prev_armed   <= 1'b0;
      siren        <= 1'b0;
      status_led   <= 1'b0;
      fuel_inhibit <= 1'b0;
    end else begin
      state        <= next_state;
      door_q       <= door_driver;
      prev_armed   <= (state == ARMED);
      siren        <= siren_c;
      status_led   <= led_c;
      fuel_inhibit <= fuel_c;
    end
  end

  // Next state and timer load; the first matching rule in each state wins.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_value = '0;
    case (state)
      DISARMED: begin
        if (!ignition && close_edge) begin
          next_state = ARMING;
          load       = 1'b1;
          load_value = TW'(T_ARM_DELAY);
        end
      end
      ARMING: begin
        if (ignition || door_driver || door_pass) begin
          next_state = DISARMED;
        end else if (expired) begin
          next_state = ARMED;
        end
      end
      ARMED: begin
        // Ignition alone never disarms here: a hot-wired car stays armed.
        if (door_driver) begin
          next_state = TRIGGERED;
          load       = 1'b1;
          load_value = TW'(T_DRIVER);
        end else if (door_pass) begin
          next_state = TRIGGERED;
          load       = 1'b1;
          load_value = TW'(T_PASSENGER);
        end
      end
      TRIGGERED: begin
        if (ignition) begin
          next_state = DISARMED;
        end else if (expired) begin
          next_state = ALARM;
          load       = 1'b1;
          load_value = TW'(T_ALARM_ON);
        end
      end
      ALARM: begin
        if (ignition) begin
          next_state = DISARMED;
        end else if (expired) begin
          if (!door_driver && !door_pass) begin
            next_state = ARMED;
          end else begin
            load       = 1'b1;
            load_value = TW'(T_ALARM_ON);
          end
        end
      end
      default: next_state = DISARMED;
    endcase
  end

  // Output values for the next clock, taken from the current state.
  always_comb begin
    siren_c = 1'b0;
    led_c   = 1'b0;
    fuel_c  = 1'b0;
    case (state)
      DISARMED: begin
        led_c = 1'b0;
      end
      ARMING: begin
        led_c = 1'b1;
      end
      ARMED: begin
        // First cycle in ARMED clears the LED; afterwards it blinks on the 1 Hz enable.
        led_c  = prev_armed ? (status_led ^ one_hz_en) : 1'b0;
        fuel_c = 1'b1;
      end
      TRIGGERED: begin
        led_c  = 1'b1;
        fuel_c = 1'b1;
      end
      ALARM: begin
        siren_c = 1'b1;
        led_c   = 1'b1;
        fuel_c  = 1'b1;
      end
      default: begin
        siren_c = 1'b0;
      end
    endcase
  end

endmodule
